// File: rtl/lu_operand_fetch.sv
// rtl/lu_operand_fetch.sv - operand fetch/issue stage with regfile, scoreboard and registered beat to the logic unit
module lu_operand_fetch #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic             lu_valid,
  input  logic             lu_ready,
  output logic [2:0]       lu_opcode,
  output logic [WIDTH-1:0] lu_arg1,
  output logic [WIDTH-1:0] lu_arg2,
  output logic [AW-1:0]    lu_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             byp1, byp2, hazard, accept;
  logic [WIDTH-1:0] rd1_val, rd2_val, arg2_val;

  // A writeback landing this cycle both forwards its data and resolves the hazard.
  assign byp1 = wb_en && (wb_addr == in_rs1);
  assign byp2 = wb_en && (wb_addr == in_rs2);

  always_comb begin
    rd1_val = regs[in_rs1];
    if (in_rs1 == '0)
      rd1_val = '0;
    else if (byp1)
      rd1_val = wb_data;
    rd2_val = regs[in_rs2];
    if (in_rs2 == '0)
      rd2_val = '0;
    else if (byp2)
      rd2_val = wb_data;
  end

  assign arg2_val = in_use_imm ? in_imm : rd2_val;
  assign hazard   = (pend[in_rs1] && !byp1) ||
                    (!in_use_imm && pend[in_rs2] && !byp2);
  assign in_ready = !hazard && (!lu_valid || lu_ready);
  assign accept   = in_valid && in_ready;

  // Clear from writeback first so a same-cycle issue to that register keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (wb_en)
      pend_nxt[wb_addr] = 1'b0;
    if (accept && (in_rd != '0))
      pend_nxt[in_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_valid  <= 1'b0;
      lu_opcode <= '0;
      lu_arg1   <= '0;
      lu_arg2   <= '0;
      lu_rd     <= '0;
    end else if (accept) begin
      lu_valid  <= 1'b1;
      lu_opcode <= in_op;
      lu_arg1   <= rd1_val;
      lu_arg2   <= arg2_val;
      lu_rd     <= in_rd;
    end else if (lu_ready) begin
      lu_valid  <= 1'b0;
    end
  end

endmodule
